// File: rtl/operand_pair_fifo.sv
// Pairs an alternating A,B serial word stream into {a,b} entries and queues them for the AND stage.
// Optional synchronous clear port enabled by defining OPERAND_PAIR_SYNC_CLEAR_EN.
module operand_pair_fifo #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
`ifdef OPERAND_PAIR_SYNC_CLEAR_EN
    input  logic              sync_clear,
`endif
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WIDTH-1:0]  out_a,
    output logic [WIDTH-1:0]  out_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   pair_count
);

    localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);

    typedef enum logic {
        ST_WAIT_A = 1'b0,
        ST_WAIT_B = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [WIDTH-1:0]    r_a_hold;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W:0]     r_count;
    logic [2*WIDTH-1:0]  r_mem [DEPTH];
    logic [2*WIDTH-1:0]  w_head;
    logic                w_clear;
    logic                w_accept;
    logic                w_push;
    logic                w_pop;

`ifdef OPERAND_PAIR_SYNC_CLEAR_EN
    assign w_clear = sync_clear;
`else
    assign w_clear = 1'b0;
`endif

    // Clear wins over every handshake, so it masks both push and pop.
    assign w_accept = in_valid & in_ready;
    assign w_push   = w_accept & (r_state == ST_WAIT_B) & ~w_clear;
    assign w_pop    = out_valid & out_ready & ~w_clear;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_WAIT_A;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_clear) begin
            w_state_next = ST_WAIT_A;
        end else if (w_accept) begin
            w_state_next = (r_state == ST_WAIT_A) ? ST_WAIT_B : ST_WAIT_A;
        end
    end

    // in_ready looks only at registered state: a full FIFO never takes B on the pop cycle.
    always_comb begin
        in_ready = 1'b1;
        if (r_state == ST_WAIT_B) begin
            in_ready = (r_count < C_DEPTH);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a_hold <= '0;
        end else if (w_clear) begin
            r_a_hold <= '0;
        end else if (w_accept && (r_state == ST_WAIT_A)) begin
            r_a_hold <= in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_mem[gi] <= '0;
                end else if (w_push && (r_wr_ptr == ADDR_W'(gi))) begin
                    r_mem[gi] <= {r_a_hold, in_data};
                end
            end
        end
    endgenerate

    assign w_head     = r_mem[r_rd_ptr];
    assign out_a      = w_head[2*WIDTH-1:WIDTH];
    assign out_b      = w_head[WIDTH-1:0];
    assign out_valid  = (r_count != '0);
    assign pair_count = r_count;

endmodule
